// File: rtl/sample_hold_ti.sv
// rtl/sample_hold_ti.sv - time-interleaved differential track-and-hold model with round-robin sequencer
module sample_hold_ti #(
    parameter int NCH       = 4,
    parameter int TRACK_CYC = 2,
    parameter int MODE      = 0,
    parameter int OVF_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  real                    vip,
    input  real                    vin,
    input  logic [NCH-1:0]         ack,
    output real                    vop [NCH],
    output real                    von [NCH],
    output logic [NCH-1:0]         vld,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic                   busy,
    output logic [OVF_W-1:0]       ovf_cnt
);
    localparam int SW = $clog2(NCH);
    localparam int CW = (TRACK_CYC > 1) ? $clog2(TRACK_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TRACK_CYC - 1);
    localparam logic [SW-1:0] CH_LAST  = SW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, TRACK, STALL} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] nxt, enter_ch;
    logic          hold, enter, ovf_inc;

    assign busy = (state != IDLE);
    assign hold = (state == TRACK) && (cnt == CNT_LAST);
    assign nxt  = (ch_sel == CH_LAST) ? '0 : ch_sel + SW'(1);

    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        enter_ch  = ch_sel;
        ovf_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = TRACK;
            end
            TRACK: begin
                if (hold) begin
                    if (!en)                                       state_nxt = IDLE;
                    else if (MODE == 0 && vld[nxt] && !ack[nxt])   state_nxt = STALL;
                    else                                           state_nxt = TRACK;
                end
            end
            STALL: begin
                if (!en)                                 state_nxt = IDLE;
                else if (ack[ch_sel] || !vld[ch_sel])    state_nxt = TRACK;
            end
            default: state_nxt = IDLE;
        endcase
        // A channel is (re)entered either from IDLE/STALL or straight after the previous hold
        enter    = (state_nxt == TRACK) && ((state != TRACK) || hold);
        enter_ch = (state == TRACK) ? nxt : ch_sel;
        ovf_inc  = (MODE != 0) && enter && vld[enter_ch] && !ack[enter_ch];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ch_sel  <= '0;
            vld     <= '0;
            ovf_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                vop[i] <= 0.0;
                von[i] <= 0.0;
            end
        end else begin
            state <= state_nxt;
            // Later assignments take priority: ack clear < entry clear < hold set
            vld <= vld & ~ack;
            if (enter) vld[enter_ch] <= 1'b0;
            if (ovf_inc && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
            if (state == TRACK) begin
                vop[ch_sel] <= vip;
                von[ch_sel] <= vin;
                if (hold) begin
                    vld[ch_sel] <= 1'b1;
                    ch_sel      <= nxt;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sample_hold_ti.sv
// tb/tb_sample_hold_ti.sv - directed bench for sample_hold_ti in stall and overwrite modes
module tb_sample_hold_ti;
    logic       clk;
    logic       rst;
    logic       en_s, en_o;
    real        vip, vin;
    logic [3:0] ack_s, ack_o;
    real        vop_s [4];
    real        von_s [4];
    real        vop_o [4];
    real        von_o [4];
    logic [3:0] vld_s, vld_o;
    logic [1:0] ch_sel_s, ch_sel_o;
    logic       busy_s, busy_o;
    logic [7:0] ovf_s;
    logic [1:0] ovf_o;

    int  n_cmp = 0;
    int  n_err = 0;
    real ramp [8];

    sample_hold_ti #(.NCH(4), .TRACK_CYC(2), .MODE(0), .OVF_W(8)) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .vip(vip), .vin(vin), .ack(ack_s),
        .vop(vop_s), .von(von_s), .vld(vld_s), .ch_sel(ch_sel_s), .busy(busy_s), .ovf_cnt(ovf_s)
    );

    sample_hold_ti #(.NCH(4), .TRACK_CYC(2), .MODE(1), .OVF_W(2)) dut_o (
        .clk(clk), .rst(rst), .en(en_o), .vip(vip), .vin(vin), .ack(ack_o),
        .vop(vop_o), .von(von_o), .vld(vld_o), .ch_sel(ch_sel_o), .busy(busy_o), .ovf_cnt(ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input real obs, input real exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %f expected %f", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en_s = 1'b0; en_o = 1'b0; ack_s = 4'h0; ack_o = 4'h0;
        vip = 0.0; vin = 0.0;
        tick();
        tick();
        chk("rst_vld", 32'(vld_s), 32'h0);
        chk("rst_ch_sel", 32'(ch_sel_s), 32'h0);
        chk("rst_busy", 32'(busy_s), 32'h0);
        chk("rst_ovf", 32'(ovf_s), 32'h0);
        chkr("rst_vop0", vop_s[0], 0.0);
        rst = 1'b0;
        tick();

        // steady round robin with ack tied high
        ack_s = 4'hF; vip = 0.3; vin = -0.3; en_s = 1'b1;
        tick();
        chk("t1_busy", 32'(busy_s), 32'h1);
        chk("t1_vld_entry", 32'(vld_s), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_vld_pre_hold", 32'(vld_s), 32'h0);
            tick();
            chk("t1_vld_hold", 32'(vld_s), 32'(1) << k);
            chk("t1_ch_sel", 32'(ch_sel_s), 32'((k + 1) % 4));
            chkr("t1_vop", vop_s[k], 0.3);
            chkr("t1_von", von_s[k], -0.3);
        end
        chk("t1_ovf", 32'(ovf_s), 32'h0);

        // ramp: each channel keeps the value present on its own hold edge
        for (int i = 0; i < 8; i++) ramp[i] = 0.5 + 0.1 * i;
        vip = ramp[0]; vin = -ramp[0];
        tick();
        chkr("t2_follow", vop_s[0], ramp[0]);
        for (int i = 1; i < 8; i++) begin
            vip = ramp[i]; vin = -ramp[i];
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chkr("t2_vop_held", vop_s[k], ramp[2 * k + 1]);
            chkr("t2_von_held", von_s[k], -ramp[2 * k + 1]);
        end

        // stall when the next channel is still unconsumed
        tick();
        ack_s = 4'h0;
        repeat (7) tick();
        chk("t3_stall_busy", 32'(busy_s), 32'h1);
        chk("t3_stall_ch_sel", 32'(ch_sel_s), 32'h0);
        chk("t3_stall_vld", 32'(vld_s), 32'hF);
        vip = 0.9;
        tick();
        chkr("t3_stall_hold_vop", vop_s[0], ramp[7]);
        chk("t3_stall_ch_sel2", 32'(ch_sel_s), 32'h0);
        chk("t3_stall_vld2", 32'(vld_s), 32'hF);
        ack_s = 4'h1;
        tick();
        chk("t3_resume_vld", 32'(vld_s), 32'hE);
        chk("t3_resume_busy", 32'(busy_s), 32'h1);
        ack_s = 4'h0;
        tick();
        chkr("t3_resume_track", vop_s[0], 0.9);
        tick();
        chk("t3_restall_vld", 32'(vld_s), 32'hF);
        chk("t3_restall_ch_sel", 32'(ch_sel_s), 32'h1);

        // en drops on the first track cycle of ch2
        ack_s = 4'hF;
        tick();
        chk("t5_drain_vld", 32'(vld_s), 32'h0);
        tick();
        tick();
        chk("t5_ch2_ch_sel", 32'(ch_sel_s), 32'h2);
        en_s = 1'b0;
        tick();
        chk("t5_still_busy", 32'(busy_s), 32'h1);
        tick();
        chk("t5_hold_vld", 32'(vld_s), 32'h4);
        chk("t5_idle_ch_sel", 32'(ch_sel_s), 32'h3);
        chk("t5_idle_busy", 32'(busy_s), 32'h0);
        tick();
        chk("t5_idle_stays", 32'(busy_s), 32'h0);
        chk("t5_ack_clears", 32'(vld_s), 32'h0);

        // overwrite mode with a 2-bit saturating counter
        en_o = 1'b1; ack_o = 4'h0;
        tick();
        repeat (8) tick();
        chk("t4_ovf1", 32'(ovf_o), 32'h1);
        chk("t4_ch_sel_h4", 32'(ch_sel_o), 32'h0);
        chk("t4_vld_h4", 32'(vld_o), 32'hE);
        repeat (2) tick();
        chk("t4_ovf2", 32'(ovf_o), 32'h2);
        chk("t4_no_stall", 32'(ch_sel_o), 32'h1);
        repeat (2) tick();
        chk("t4_ovf3", 32'(ovf_o), 32'h3);
        repeat (6) tick();
        chk("t4_ovf_sat", 32'(ovf_o), 32'h3);
        chk("t4_busy", 32'(busy_o), 32'h1);
        chk("t4_ch_sel_h9", 32'(ch_sel_o), 32'h1);

        // asynchronous reset mid-track of ch1
        vip = 0.7;
        tick();
        chkr("t6_track_ch1", vop_o[1], 0.7);
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chkr("t6_vop_rst", vop_o[k], 0.0);
            chkr("t6_von_rst", von_o[k], 0.0);
        end
        chk("t6_vld_rst", 32'(vld_o), 32'h0);
        chk("t6_ch_sel_rst", 32'(ch_sel_o), 32'h0);
        chk("t6_ovf_rst", 32'(ovf_o), 32'h0);
        chk("t6_busy_rst", 32'(busy_o), 32'h0);
        chk("t6_ch_sel_s_rst", 32'(ch_sel_s), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
